// File: rtl/knap_enum_search_if.sv
// Bundle between the enumeration driver and the knapsack checker plus its controller.
// Handshake: start is a level request taken only at an IDLE edge; every taken start ends in exactly one done pulse unless rst intervenes.
interface knap_enum_search_if;
    logic       start;
    logic       first_only;
    logic       valid_in;
    logic [5:0] sel;
    logic       busy;
    logic       done;
    logic       found;
    logic [6:0] sol_count;
    logic [5:0] best_sel;
    logic [7:0] best_value;

    modport master (
        output start, first_only, valid_in,
        input  sel, busy, done, found, sol_count, best_sel, best_value
    );

    modport slave (
        input  start, first_only, valid_in,
        output sel, busy, done, found, sol_count, best_sel, best_value
    );
endinterface

// File: rtl/knap_enum_search.sv
// Walks all 64 item selections through a combinational feasibility checker and
// keeps the feasible count plus the highest-value (earliest on ties) selection.
module knap_enum_search #(
    parameter logic [7:0] V_A = 8'd4,
    parameter logic [7:0] V_B = 8'd8,
    parameter logic [7:0] V_C = 8'd0,
    parameter logic [7:0] V_D = 8'd20,
    parameter logic [7:0] V_E = 8'd10,
    parameter logic [7:0] V_F = 8'd12
) (
    input  logic                     clk,
    input  logic                     rst,
    knap_enum_search_if.slave        bus,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic       first_only_q, first_only_d;
    logic       found_q, found_d;
    logic [6:0] count_q, count_d;
    logic [5:0] best_sel_q, best_sel_d;
    logic [7:0] best_value_q, best_value_d;
    logic [7:0] cand_value;

    // Same 8-bit wrapping sum the checker uses.
    function automatic logic [7:0] sel_value(input logic [5:0] s);
        logic [7:0] v;
        v = 8'd0;
        if (s[0]) v = v + V_A;
        if (s[1]) v = v + V_B;
        if (s[2]) v = v + V_C;
        if (s[3]) v = v + V_D;
        if (s[4]) v = v + V_E;
        if (s[5]) v = v + V_F;
        return v;
    endfunction

    assign cand_value = sel_value(idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 6'd0;
            first_only_q <= 1'b0;
            found_q      <= 1'b0;
            count_q      <= 7'd0;
            best_sel_q   <= 6'd0;
            best_value_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            first_only_q <= first_only_d;
            found_q      <= found_d;
            count_q      <= count_d;
            best_sel_q   <= best_sel_d;
            best_value_q <= best_value_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        first_only_d = first_only_q;
        found_d      = found_q;
        count_d      = count_q;
        best_sel_d   = best_sel_q;
        best_value_d = best_value_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_SCAN;
                    first_only_d = bus.first_only;
                    idx_d        = 6'd0;
                    found_d      = 1'b0;
                    count_d      = 7'd0;
                    best_sel_d   = 6'd0;
                    best_value_d = 8'd0;
                end
            end
            S_SCAN: begin
                if (bus.valid_in) begin
                    count_d = count_q + 7'd1;
                    found_d = 1'b1;
                    // Strict compare keeps the lower index on equal value.
                    if (!found_q || (cand_value > best_value_q)) begin
                        best_sel_d   = idx_q;
                        best_value_d = cand_value;
                    end
                end
                if ((idx_q == 6'd63) || (first_only_q && bus.valid_in)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.sel        = idx_q;
    assign bus.busy       = (state_q == S_SCAN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.found      = found_q;
    assign bus.sol_count  = count_q;
    assign bus.best_sel   = best_sel_q;
    assign bus.best_value = best_value_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_knap_enum_search.sv
// Directed bench for knap_enum_search with a behavioural checker stand-in whose
// feasible set is chosen per test.
module tb_knap_enum_search;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [1:0] chk_mode;   // 0: never, 1: always, 2: only 0x2A, 3: only sel==5
    int         n_vec;
    int         n_miss;
    int         busy_n;
    bit         saw_done;
    bit         spur_done;

    knap_enum_search_if bus ();

    knap_enum_search dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    assign bus.valid_in = (chk_mode == 2'd1) ||
                          ((chk_mode == 2'd2) && (bus.sel == 6'h2A)) ||
                          ((chk_mode == 2'd3) && (bus.sel == 6'd5));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_results(input string tag, input logic f, input logic [6:0] c,
                                  input logic [5:0] s, input logic [7:0] v);
        check({tag, ".found"},      {31'd0, bus.found},      {31'd0, f});
        check({tag, ".sol_count"},  {25'd0, bus.sol_count},  {25'd0, c});
        check({tag, ".best_sel"},   {26'd0, bus.best_sel},   {26'd0, s});
        check({tag, ".best_value"}, {24'd0, bus.best_value}, {24'd0, v});
    endtask

    // Called at a negedge inside SCAN; returns at the negedge where done is seen.
    task automatic wait_done(output int nb, output bit seen);
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nb++;
            @(negedge clk);
        end
    endtask

    task automatic do_scan(input logic fo, output int nb, output bit seen);
        bus.first_only = fo;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        wait_done(nb, seen);
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        chk_mode       = 2'd2;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.first_only = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.state", {30'd0, dbg_state}, 32'd0);
        check("rst.sel",   {26'd0, bus.sel},   32'd0);
        check("rst.busy",  {31'd0, bus.busy},  32'd0);
        check("rst.done",  {31'd0, bus.done},  32'd0);
        expect_results("rst", 1'b0, 7'd0, 6'd0, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: checker accepts only B+D+F
        do_scan(1'b0, busy_n, saw_done);
        check("t1.done_seen", {31'd0, saw_done}, 32'd1);
        check("t1.busy_cycles", busy_n, 32'd64);
        check("t1.busy_at_done", {31'd0, bus.busy}, 32'd0);
        expect_results("t1", 1'b1, 7'd1, 6'h2A, 8'd40);
        @(negedge clk);
        check("t1.done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("t1.idle_state", {30'd0, dbg_state}, 32'd0);
        expect_results("t1.hold", 1'b1, 7'd1, 6'h2A, 8'd40);

        // 2: everything feasible; 0x3B and 0x3F tie at 54
        chk_mode = 2'd1;
        do_scan(1'b0, busy_n, saw_done);
        check("t2.done_seen", {31'd0, saw_done}, 32'd1);
        expect_results("t2", 1'b1, 7'd64, 6'h3B, 8'd54);
        @(negedge clk);

        // 3: first_only stops at idx 5
        chk_mode = 2'd3;
        do_scan(1'b1, busy_n, saw_done);
        check("t3.done_seen", {31'd0, saw_done}, 32'd1);
        check("t3.busy_cycles", busy_n, 32'd6);
        check("t3.sel_at_done", {26'd0, bus.sel}, 32'd5);
        expect_results("t3", 1'b1, 7'd1, 6'd5, 8'd4);
        @(negedge clk);
        check("t3.sel_held", {26'd0, bus.sel}, 32'd5);

        // 4: nothing feasible
        chk_mode = 2'd0;
        do_scan(1'b0, busy_n, saw_done);
        check("t4.done_seen", {31'd0, saw_done}, 32'd1);
        check("t4.busy_cycles", busy_n, 32'd64);
        expect_results("t4", 1'b0, 7'd0, 6'd0, 8'd0);
        @(negedge clk);

        // 5a: start re-pulsed at idx 20 is ignored
        chk_mode       = 2'd2;
        bus.first_only = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n    = 0;
        saw_done  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                saw_done = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
            bus.start = bus.busy && (bus.sel == 6'd20);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("t5.done_seen", {31'd0, saw_done}, 32'd1);
        check("t5.busy_cycles", busy_n, 32'd64);
        expect_results("t5", 1'b1, 7'd1, 6'h2A, 8'd40);
        @(negedge clk);

        // 5b: async reset at idx 30 of an all-feasible scan
        chk_mode  = 2'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.sel == 6'd30) break;
            @(negedge clk);
        end
        check("t5.reached_idx30", {26'd0, bus.sel}, 32'd30);
        rst = 1'b1;
        #1;
        check("t5.rst_state", {30'd0, dbg_state}, 32'd0);
        check("t5.rst_sel",   {26'd0, bus.sel},   32'd0);
        check("t5.rst_busy",  {31'd0, bus.busy},  32'd0);
        expect_results("t5.rst", 1'b0, 7'd0, 6'd0, 8'd0);
        @(negedge clk);
        rst       = 1'b0;
        spur_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) spur_done = 1'b1;
        end
        check("t5.no_done_after_rst", {31'd0, spur_done}, 32'd0);
        chk_mode = 2'd2;
        do_scan(1'b0, busy_n, saw_done);
        check("t5.clean_busy_cycles", busy_n, 32'd64);
        expect_results("t5.clean", 1'b1, 7'd1, 6'h2A, 8'd40);
        @(negedge clk);

        // 6: start held high, second scan must clear the all-feasible results
        chk_mode       = 2'd1;
        bus.first_only = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        wait_done(busy_n, saw_done);
        check("t6.first_done", {31'd0, saw_done}, 32'd1);
        expect_results("t6.first", 1'b1, 7'd64, 6'h3B, 8'd54);
        chk_mode = 2'd2;
        @(negedge clk);
        check("t6.idle_gap", {30'd0, dbg_state}, 32'd0);
        check("t6.idle_hold", {25'd0, bus.sol_count}, 32'd64);
        @(negedge clk);
        check("t6.restart_busy", {31'd0, bus.busy}, 32'd1);
        check("t6.cleared_count", {25'd0, bus.sol_count}, 32'd0);
        wait_done(busy_n, saw_done);
        bus.start = 1'b0;
        check("t6.second_done", {31'd0, saw_done}, 32'd1);
        check("t6.second_busy", busy_n, 32'd64);
        expect_results("t6.second", 1'b1, 7'd1, 6'h2A, 8'd40);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
